// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings and responder FSM states shared by
// data_memory_responder and lane_formatter.
package dmem_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;
endpackage

// File: rtl/lane_formatter.sv
// lane_formatter: extracts and extends the addressed load lane, and merges
// store data into the addressed lane(s) of a memory word.
module lane_formatter
    import dmem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    logic [31:0] lanes;
    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = rdata[{addr[1], 4'b0000} +: 16];
        load_data = size == SIZE_BYTE ? {{24{b[7] & ~zext}}, b} :
                    size == SIZE_HALF ? {{16{h[15] & ~zext}}, h} : rdata;
        // store data is replicated to every lane; the mask picks the target lane(s)
        mask = size == SIZE_BYTE ? 32'hFF << {addr, 3'b000} :
               size == SIZE_HALF ? 32'hFFFF << {addr[1], 4'b0000} : 32'hFFFF_FFFF;
        lanes = size == SIZE_BYTE ? {4{wdata[7:0]}} :
                size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
        merge_data = (rdata & ~mask) | (lanes & mask);
    end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: CPU load/store front end to a word-wide synchronous memory.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int WORD_AW = ADDR_W - 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_zext,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic [WORD_AW-1:0] mem_addr,
    output logic               mem_re,
    input  logic [31:0]        mem_rdata,
    output logic               mem_we,
    output logic [31:0]        mem_wdata
);
    state_t      state;
    logic [1:0]  addr_lo;
    logic        we_q;
    logic [1:0]  size_q;
    logic        zext_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        illegal;

    always_comb begin
`ifdef MISALIGN_TRAP_EN
        illegal = req_size == SIZE_ILL ||
                  (req_size == SIZE_HALF && req_addr[0]) ||
                  (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
`else
        illegal = req_size == SIZE_ILL;
`endif
    end

    lane_formatter u_fmt (
        .addr       (addr_lo),
        .size       (size_q),
        .zext       (zext_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            addr_lo    <= '0;
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            zext_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_lo   <= req_addr[1:0];
                        we_q      <= req_we;
                        size_q    <= req_size;
                        zext_q    <= req_zext;
                        wdata_q   <= req_wdata;
                        mem_addr  <= WORD_AW'(req_addr >> 2);
                        if (illegal) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else if (req_we && req_size == SIZE_WORD) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                            state     <= WRITE;
                        end else begin
                            mem_re <= 1'b1;
                            state  <= READ;
                        end
                    end
                end
                READ: state <= CAPTURE;
                // mem_rdata is valid this cycle: finish a load or merge a partial store
                CAPTURE: begin
                    if (we_q) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= merge_data;
                        state     <= WRITE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed and random load/store checks of
// data_memory_responder against a word-array reference model.
module tb_data_memory_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_zext = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [13:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;
    logic        mem_we;
    logic [31:0] mem_wdata;

    logic [31:0] mem [0:16383];
    logic [31:0] ref_mem [0:63];
    logic        init_done = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    data_memory_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_zext   (req_zext),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return i == 4 ? 32'h80FF_7F01 : (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // synchronous memory: read data appears the cycle after mem_re
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            init_done <= 1'b1;
        end
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string tag, input logic [15:0] a, input logic we, input logic [1:0] sz,
                       input logic zx, input logic [31:0] wd, input int hold, output logic [31:0] rd);
        logic [31:0] w, v, exp_rd;
        int b, exp_lat, exp_re, exp_we, exp_wek, lat, re_n, we_n, we_k, both, n;
        logic trap;
        b = int'(a[1:0]);
        w = ref_mem[a[7:2]];
        trap = sz == 2'd3;
`ifdef MISALIGN_TRAP_EN
        trap = trap || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`endif
        exp_rd = 32'h0;
        exp_wek = 0;
        if (trap) begin
            exp_lat = 1; exp_re = 0; exp_we = 0;
        end else if (!we) begin
            if (sz == 2'd0) begin
                v = (w >> (8 * b)) & 32'hFF;
                if (!zx && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                v = (w >> (16 * (b / 2))) & 32'hFFFF;
                if (!zx && v[15]) v = v | 32'hFFFF_0000;
            end else v = w;
            exp_rd = v; exp_lat = 3; exp_re = 1; exp_we = 0;
        end else if (sz == 2'd2) begin
            w = wd; exp_lat = 2; exp_re = 0; exp_we = 1; exp_wek = 1;
        end else begin
            if (sz == 2'd0) w = (w & ~(32'hFF << (8 * b))) | ((wd & 32'hFF) << (8 * b));
            else w = (w & ~(32'hFFFF << (16 * (b / 2)))) | ((wd & 32'hFFFF) << (16 * (b / 2)));
            exp_lat = 4; exp_re = 1; exp_we = 1; exp_wek = 3;
        end
        rd = 32'h0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        if (!req_ready) return;
        req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz; req_zext = zx; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = $urandom;
        lat = 0; re_n = 0; we_n = 0; we_k = 0; both = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (mem_re) re_n++;
            if (mem_we) begin we_n++; we_k = k; end
            if (mem_re && mem_we) both++;
            if (resp_valid) lat = k;
            else @(negedge clk);
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".err"}, 32'(resp_err), 32'(trap));
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".re_cnt"}, 32'(re_n), 32'(exp_re));
        chk({tag, ".we_cnt"}, 32'(we_n), 32'(exp_we));
        if (exp_we != 0) chk({tag, ".we_cyc"}, 32'(we_k), 32'(exp_wek));
        chk({tag, ".re_we_overlap"}, 32'(both), 32'd0);
        rd = resp_rdata;
        for (int k = 0; k < hold; k++) begin
            chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, resp_rdata, exp_rd);
            chk({tag, ".hold_err"}, 32'(resp_err), 32'(trap));
            chk({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
            chk({tag, ".hold_mem"}, 32'(mem_re | mem_we), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        chk({tag, ".consume_rdy"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, ".post_rdy"}, 32'(req_ready), 32'd1);
        if (!trap && we) begin
            ref_mem[a[7:2]] = w;
            chk({tag, ".mem"}, mem[a[7:2]], w);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] wd;
        int we_n;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.mem_strobes", 32'({mem_re, mem_we}), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready_after", 32'(req_ready), 32'd1);

        txn("ld_b11_s", 16'h0011, 1'b0, 2'd0, 1'b0, 32'h0, 0, rd);
        chk("ld_b11_s.const", rd, 32'h0000_007F);
        txn("ld_b12_s", 16'h0012, 1'b0, 2'd0, 1'b0, 32'h0, 0, rd);
        chk("ld_b12_s.const", rd, 32'hFFFF_FFFF);
        txn("ld_b12_z", 16'h0012, 1'b0, 2'd0, 1'b1, 32'h0, 0, rd);
        chk("ld_b12_z.const", rd, 32'h0000_00FF);
        txn("illegal", 16'h0010, 1'b0, 2'd3, 1'b0, 32'h0, 0, rd);
        txn("ld_w11", 16'h0011, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd);
`ifdef MISALIGN_TRAP_EN
        chk("ld_w11.const", rd, 32'h0);
`else
        chk("ld_w11.const", rd, 32'h80FF_7F01);
`endif
        txn("hold5", 16'h0010, 1'b0, 2'd2, 1'b0, 32'h0, 5, rd);
        txn("st_h12", 16'h0012, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 0, rd);
        chk("st_h12.const", mem[4], 32'hBEEF_7F01);
        txn("st_w20", 16'h0020, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, rd);
        chk("st_w20.const", mem[8], 32'hDEAD_BEEF);

        for (int i = 0; i < 40; i++)
            txn($sformatf("rnd%0d", i), 16'($urandom_range(0, 255)), 1'($urandom), 2'($urandom),
                1'($urandom), $urandom, int'($urandom_range(0, 2)), rd);

        // reset arrives while a byte store sits in CAPTURE
        while (!req_ready) @(negedge clk);
        wd = $urandom;
        req_valid = 1'b1; req_addr = 16'h0015; req_we = 1'b1; req_size = 2'd0; req_zext = 1'b0; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        we_n = int'(mem_we);
        @(negedge clk);
        we_n += int'(mem_we);
        rst_n = 1'b0;
        #1;
        chk("abort.resp_valid", 32'(resp_valid), 32'd0);
        chk("abort.req_ready", 32'(req_ready), 32'd0);
        chk("abort.mem_we_now", 32'(mem_we), 32'd0);
        repeat (3) begin
            @(negedge clk);
            we_n += int'(mem_we);
        end
        rst_n = 1'b1;
        @(negedge clk);
        we_n += int'(mem_we);
        chk("abort.ready_after", 32'(req_ready), 32'd1);
        chk("abort.resp_after", 32'(resp_valid), 32'd0);
        chk("abort.we_cnt", 32'(we_n), 32'd0);
        chk("abort.mem", mem[5], ref_mem[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: width of the byte address.
REQ-002 SHALL have parameter WORD_AW, default ADDR_W-2: width of the word address driven to memory.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the CPU presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder accepts a request.
REQ-007 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_zext, input, 1 bit: load zero-extension; 0 = sign-extend.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1 bit: a response is pending.
REQ-013 SHALL have port resp_ready, input, 1 bit: the CPU consumes the response.
REQ-014 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1 bit: the request was rejected with no memory access.
REQ-016 SHALL have port mem_addr, output, WORD_AW bits: word address (req_addr[ADDR_W-1:2]).
REQ-017 SHALL have port mem_re, output, 1 bit: read strobe; mem_rdata is valid exactly 1 cycle later.
REQ-018 SHALL have port mem_rdata, input, 32 bits: memory read word.
REQ-019 SHALL have ports mem_we, output, 1 bit, and mem_wdata, output, 32 bits: full-word write strobe and data.

Function
REQ-020 SHALL implement an FSM with states IDLE, READ, CAPTURE, WRITE and RESP.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted in cycle N when req_valid && req_ready, and all request fields are registered at that edge.
REQ-022 SHALL take a load along IDLE->READ (mem_re=1, N+1)->CAPTURE (N+2)->RESP (resp_valid from N+3).
REQ-023 SHALL take a word store along IDLE->WRITE (mem_we=1, N+1)->RESP (N+2), with no read.
REQ-024 SHALL take a byte/half store along IDLE->READ->CAPTURE (merge)->WRITE (N+3)->RESP (N+4), replacing only the addressed lane(s).
REQ-025 SHALL send size 11 directly IDLE->RESP (N+1) with resp_err=1, asserting neither mem_re nor mem_we.
REQ-026 SHALL select the load byte lane by addr[1:0] and the half lane by addr[1], then sign- or zero-extend to 32 bits per req_zext.
REQ-027 SHALL pulse mem_re and mem_we for exactly one cycle per access and never assert them together.
REQ-028 SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready; RESP->IDLE on resp_valid && resp_ready.
REQ-029 SHALL NOT accept a new request in the cycle its response is consumed; the earliest next accept is the following cycle.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_addr=0 and mem_wdata=0 asynchronously.
REQ-031 SHALL assert req_ready in the first cycle after rst_n deasserts.
REQ-032 SHALL, on reset mid-operation, abort the in-flight request with no response; a store reset before WRITE leaves memory unmodified.

Configuration
REQ-033 SHALL, when MISALIGN_TRAP_EN is defined, reject a half with addr[0]=1 or a word with addr[1:0]!=0 as in REQ-025 (resp_err=1, no memory access).
REQ-034 SHALL, when MISALIGN_TRAP_EN is undefined, ignore the excess low address bits (half uses addr[1]; word ignores addr[1:0]) and not assert resp_err for misalignment.

Structure
REQ-035 SHALL place the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state enum in shared package dmem_pkg.
REQ-036 SHALL implement lane extract/extend and lane merge as a combinational sub-module lane_formatter.

Verification
REQ-037 SHALL verify: memory[0x10]=0x80FF7F01; load byte at 0x11, zext=0 -> 0x0000007F; at 0x12, zext=0 -> 0xFFFFFFFF; at 0x12, zext=1 -> 0x000000FF; resp_valid at N+3 each time.
REQ-038 SHALL verify: store half 0xBEEF at 0x12 over 0x80FF7F01 -> memory 0xBEEF7F01, one mem_we pulse at N+3, resp_valid at N+4 with resp_rdata=0.
REQ-039 SHALL verify: store word 0xDEADBEEF at 0x20 -> no mem_re, mem_we at N+1, memory[0x20]=0xDEADBEEF.
REQ-040 SHALL verify: size 11 -> resp_err=1 at N+1, zero mem_re/mem_we pulses; load word at 0x11 -> resp_err=1 with MISALIGN_TRAP_EN, else 0x80FF7F01.
REQ-041 SHALL verify: resp_ready held 0 for 5 cycles -> response stable and req_ready=0 throughout; consumed on cycle 6, next accept on cycle 7.
REQ-042 SHALL verify: rst_n pulled low during CAPTURE of a byte store -> mem_we never asserts, memory unchanged, resp_valid=0, req_ready=1 one cycle after release.
